// File: rtl/lc3b_types.sv
// Shared LC-3b datapath types used by the memory bridge.
// Contents:
//   lc3b_word       - 16-bit data/address word
//   lc3b_mem_wmask  - 2-bit byte-lane mask ([1]=high byte, [0]=low byte)
//   WMASK_FULL/NONE - common lane masks
//   same_word()     - true when two byte addresses fall in the same 16-bit word
package lc3b_types;

  typedef logic [15:0] lc3b_word;
  typedef logic [1:0]  lc3b_mem_wmask;

  localparam lc3b_mem_wmask WMASK_FULL = 2'b11;
  localparam lc3b_mem_wmask WMASK_NONE = 2'b00;

  // Byte addresses share a word when everything above the lane bit matches.
  function automatic logic same_word(input lc3b_word a, input lc3b_word b);
    return (a[15:1] == b[15:1]);
  endfunction

endpackage

// File: rtl/mem_bridge_wbuf.sv
// One-entry posted write buffer for mem_bridge.
// Ports:
//   clk, reset        - clock and synchronous active-high reset (discards the entry)
//   i_load            - capture address/data/lanes and mark the entry valid
//   i_clear           - invalidate the entry once it has reached physical memory
//   i_address/i_data/i_byte_enable - store being posted
//   i_match_address   - address of an incoming read to compare against the entry
//   o_valid/o_address/o_data/o_byte_enable - current entry contents
//   o_full_hit        - entry valid, same word as i_match_address, both lanes written
module mem_bridge_wbuf
  import lc3b_types::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          i_load,
  input  logic          i_clear,
  input  lc3b_word      i_address,
  input  lc3b_word      i_data,
  input  lc3b_mem_wmask i_byte_enable,
  input  lc3b_word      i_match_address,
  output logic          o_valid,
  output lc3b_word      o_address,
  output lc3b_word      o_data,
  output lc3b_mem_wmask o_byte_enable,
  output logic          o_full_hit
);

  logic          r_valid;
  lc3b_word      r_address;
  lc3b_word      r_data;
  lc3b_mem_wmask r_byte_enable;

  // Load wins over clear; the controller never asks for both in one cycle,
  // but a fresh store must never be lost to a stale clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid       <= 1'b0;
      r_address     <= '0;
      r_data        <= '0;
      r_byte_enable <= WMASK_NONE;
    end else if (i_load) begin
      r_valid       <= 1'b1;
      r_address     <= i_address;
      r_data        <= i_data;
      r_byte_enable <= i_byte_enable;
    end else if (i_clear) begin
      r_valid       <= 1'b0;
    end
  end

  // Only a full-word entry can satisfy a read; partial entries are never merged.
  assign o_full_hit    = r_valid && same_word(r_address, i_match_address) &&
                         (r_byte_enable == WMASK_FULL);
  assign o_valid       = r_valid;
  assign o_address     = r_address;
  assign o_data        = r_data;
  assign o_byte_enable = r_byte_enable;

endmodule

// File: rtl/mem_bridge.sv
// CPU-to-physical-memory bridge with a one-entry posted write buffer.
// Writes complete to the CPU immediately when the buffer is free and drain
// later; full-word reads that hit the buffer are forwarded from it.
// Ports:
//   clk, reset                      - clock, synchronous active-high reset
//   cpu_read/cpu_write              - CPU requests, held until cpu_resp
//   cpu_byte_enable/address/wdata   - CPU store lanes, byte address, store data
//   cpu_rdata, cpu_resp             - registered read data, one-cycle completion
//   pmem_read/pmem_write            - physical memory strobes
//   pmem_byte_enable/address/wdata  - physical request fields
//   pmem_rdata, pmem_resp           - physical read data and completion
//   wb_valid                        - write buffer holds an undrained store
module mem_bridge
  import lc3b_types::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_read,
  input  logic          cpu_write,
  input  lc3b_mem_wmask cpu_byte_enable,
  input  lc3b_word      cpu_address,
  input  lc3b_word      cpu_wdata,
  output lc3b_word      cpu_rdata,
  output logic          cpu_resp,
  output logic          pmem_read,
  output logic          pmem_write,
  output lc3b_mem_wmask pmem_byte_enable,
  output lc3b_word      pmem_address,
  output lc3b_word      pmem_wdata,
  input  lc3b_word      pmem_rdata,
  input  logic          pmem_resp,
  output logic          wb_valid
);

  typedef enum logic [1:0] {IDLE, ACK, READ, DRAIN} state_t;

  state_t        r_state;
  state_t        w_next_state;
  lc3b_word      r_rdata;
  logic          w_buf_load;
  logic          w_buf_clear;
  logic          w_load_fwd;
  logic          w_load_pmem;
  logic          w_buf_valid;
  logic          w_full_hit;
  lc3b_word      w_buf_address;
  lc3b_word      w_buf_data;
  lc3b_mem_wmask w_buf_byte_enable;

  mem_bridge_wbuf u_wbuf (
    .clk             (clk),
    .reset           (reset),
    .i_load          (w_buf_load),
    .i_clear         (w_buf_clear),
    .i_address       (cpu_address),
    .i_data          (cpu_wdata),
    .i_byte_enable   (cpu_byte_enable),
    .i_match_address (cpu_address),
    .o_valid         (w_buf_valid),
    .o_address       (w_buf_address),
    .o_data          (w_buf_data),
    .o_byte_enable   (w_buf_byte_enable),
    .o_full_hit      (w_full_hit)
  );

  // State register; reset abandons any READ/DRAIN so the strobe falls at once.
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next_state;
  end

  // Read data is only loaded by a forward or a physical read response and
  // otherwise keeps its last value.
  always_ff @(posedge clk) begin
    if (reset)            r_rdata <= '0;
    else if (w_load_fwd)  r_rdata <= w_buf_data;
    else if (w_load_pmem) r_rdata <= pmem_rdata;
  end

  // Next-state and output decode. Reads take priority over writes, and any
  // buffered store that could be reordered against the request is drained
  // first, which keeps stores in program order. pmem_resp is only looked at
  // in READ and DRAIN.
  always_comb begin
    w_next_state     = r_state;
    w_buf_load       = 1'b0;
    w_buf_clear      = 1'b0;
    w_load_fwd       = 1'b0;
    w_load_pmem      = 1'b0;
    cpu_resp         = 1'b0;
    pmem_read        = 1'b0;
    pmem_write       = 1'b0;
    pmem_byte_enable = WMASK_NONE;
    pmem_address     = cpu_address;
    pmem_wdata       = w_buf_data;
    case (r_state)
      IDLE: begin
        if (cpu_read) begin
          if (w_full_hit) begin
            w_load_fwd   = 1'b1;
            w_next_state = ACK;
          end else if (w_buf_valid) begin
            w_next_state = DRAIN;
          end else begin
            w_next_state = READ;
          end
        end else if (cpu_write) begin
          if (!w_buf_valid) begin
            w_buf_load   = 1'b1;
            w_next_state = ACK;
          end else begin
            w_next_state = DRAIN;
          end
        end else if (w_buf_valid) begin
          w_next_state = DRAIN;
        end
      end
      ACK: begin
        cpu_resp     = 1'b1;
        w_next_state = IDLE;
      end
      READ: begin
        pmem_read        = 1'b1;
        pmem_byte_enable = WMASK_FULL;
        pmem_address     = cpu_address;
        if (pmem_resp) begin
          w_load_pmem  = 1'b1;
          w_next_state = ACK;
        end
      end
      DRAIN: begin
        pmem_write       = 1'b1;
        pmem_byte_enable = w_buf_byte_enable;
        pmem_address     = w_buf_address;
        if (pmem_resp) begin
          w_buf_clear  = 1'b1;
          w_next_state = IDLE;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  assign cpu_rdata = r_rdata;
  assign wb_valid  = w_buf_valid;

endmodule
